// File: rtl/reservation_station.sv
// Purpose: ALU/branch reservation station; holds dispatched ops until both operands arrive on a CDB, then issues one per cycle.
// Latency: a dispatch with ready operands issues one edge after it is written; a CDB wakeup issues one edge after the wakeup edge.
// Backpressure: rs_full asserts while one or fewer entries are free, so an already-registered dispatch still finds a slot.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             dispatch_rs_rdy,
  input  logic [31:0]      to_inst,
  input  logic [31:0]      to_npc,
  input  logic [31:0]      to_imme,
  input  logic [31:0]      to_rs1_val,
  input  logic [31:0]      to_rs2_val,
  input  logic             to_rs1_pend,
  input  logic             to_rs2_pend,
  input  logic [TAG_W-1:0] to_rs1_tag,
  input  logic [TAG_W-1:0] to_rs2_tag,
  input  logic [TAG_W-1:0] to_dest_tag,
  input  logic             alu_cdb_en,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_en,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_val,
  input  logic             rob_clear,
  output logic             rs_full,
  output logic             alu_en,
  output logic [31:0]      alu_inst,
  output logic [31:0]      alu_npc,
  output logic [31:0]      alu_imme,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [TAG_W-1:0] alu_dest_tag
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic             busy;
    logic [31:0]      inst;
    logic [31:0]      npc;
    logic [31:0]      imme;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             qj_pend;
    logic             qk_pend;
    logic [TAG_W-1:0] dest;
  } rs_entry_t;

  rs_entry_t ent_q  [RS_SIZE];
  rs_entry_t ent_wk [RS_SIZE];
  rs_entry_t ent_new;

  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] free_cnt;
  logic             issue_vld;
  logic [IDX_W-1:0] issue_idx;

  // Snoop both result buses for one operand; returns {pend, val}. ALU bus wins a double match.
  function automatic logic [32:0] snoop(
    input logic             pend,
    input logic [TAG_W-1:0] tag,
    input logic [31:0]      val,
    input logic             a_en,
    input logic [TAG_W-1:0] a_tag,
    input logic [31:0]      a_val,
    input logic             l_en,
    input logic [TAG_W-1:0] l_tag,
    input logic [31:0]      l_val
  );
    logic [32:0] res;
    res = {pend, val};
    if (pend && a_en && (a_tag == tag)) begin
      res = {1'b0, a_val};
    end else if (pend && l_en && (l_tag == tag)) begin
      res = {1'b0, l_val};
    end
    return res;
  endfunction

  // Wakeup of resident entries and bypass capture for the incoming dispatch.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_wk[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_wk[i].qj_pend, ent_wk[i].vj} = snoop(ent_q[i].qj_pend, ent_q[i].qj, ent_q[i].vj,
                                                  alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                                  lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
        {ent_wk[i].qk_pend, ent_wk[i].vk} = snoop(ent_q[i].qk_pend, ent_q[i].qk, ent_q[i].vk,
                                                  alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                                  lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
      end
    end
    ent_new      = '0;
    ent_new.busy = 1'b1;
    ent_new.inst = to_inst;
    ent_new.npc  = to_npc;
    ent_new.imme = to_imme;
    ent_new.qj   = to_rs1_tag;
    ent_new.qk   = to_rs2_tag;
    ent_new.dest = to_dest_tag;
    {ent_new.qj_pend, ent_new.vj} = snoop(to_rs1_pend, to_rs1_tag, to_rs1_val,
                                          alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                          lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
    {ent_new.qk_pend, ent_new.vk} = snoop(to_rs2_pend, to_rs2_tag, to_rs2_val,
                                          alu_cdb_en, alu_cdb_tag, alu_cdb_val,
                                          lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val);
  end

  // Lowest-index free slot, free count, and lowest-index ready entry from registered state.
  always_comb begin
    free_vld  = 1'b0;
    free_idx  = '0;
    free_cnt  = '0;
    issue_vld = 1'b0;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
        free_cnt = free_cnt + CNT_W'(1);
      end
      if (ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  // One spare slot covers the dispatch already in flight from the upstream register.
  always_comb begin
    rs_full = (free_cnt <= CNT_W'(1));
  end

  // Entry table and issue register; reset beats stall beats flush beats normal operation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      alu_en       <= 1'b0;
      alu_inst     <= '0;
      alu_npc      <= '0;
      alu_imme     <= '0;
      alu_vj       <= '0;
      alu_vk       <= '0;
      alu_dest_tag <= '0;
    end else if (!rdy_in) begin
      alu_en <= 1'b0;
    end else if (rob_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i].busy <= 1'b0;
      end
      alu_en <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_wk[i];
      end
      if (issue_vld) begin
        ent_q[issue_idx].busy <= 1'b0;
        alu_en       <= 1'b1;
        alu_inst     <= ent_q[issue_idx].inst;
        alu_npc      <= ent_q[issue_idx].npc;
        alu_imme     <= ent_q[issue_idx].imme;
        alu_vj       <= ent_q[issue_idx].vj;
        alu_vk       <= ent_q[issue_idx].vk;
        alu_dest_tag <= ent_q[issue_idx].dest;
      end else begin
        alu_en <= 1'b0;
      end
      // The free slot is never the issuing slot, so these writes cannot collide.
      if (dispatch_rs_rdy && free_vld) begin
        ent_q[free_idx] <= ent_new;
      end
    end
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, 8, number of entries (power of two, 2-16).
REQ-002 Parameter TAG_W, 4, ROB tag width.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 rdy_in  input  1  global enable; low: all state held, alu_en driven 0.
REQ-006 dispatch_rs_rdy  input  1  dispatch valid for an ALU/branch instruction.
REQ-007 to_inst / to_npc / to_imme  input  32 each  instruction word, next PC, immediate.
REQ-008 to_rs1_val, to_rs2_val  input  32 each  operand values (meaningful when not pending).
REQ-009 to_rs1_pend, to_rs2_pend  input  1 each  operand awaits producer tag.
REQ-010 to_rs1_tag, to_rs2_tag, to_dest_tag  input  TAG_W each  producer tags; destination ROB tag.
REQ-011 alu_cdb_en, alu_cdb_tag, alu_cdb_val  input  1/TAG_W/32  ALU result broadcast.
REQ-012 lsb_cdb_en, lsb_cdb_tag, lsb_cdb_val  input  1/TAG_W/32  load result broadcast.
REQ-013 rob_clear  input  1  misprediction flush.
REQ-014 rs_full  output  1  back-pressure to fetch.
REQ-015 alu_en  output  1  registered issue strobe, one cycle per instruction.
REQ-016 alu_inst, alu_npc, alu_imme, alu_vj, alu_vk  output  32 each  registered issue payload.
REQ-017 alu_dest_tag  output  TAG_W  registered destination tag.

Function
REQ-018 Entry state: busy, inst, npc, imme, Vj, Vk, Qj, Qk, Qj_pend, Qk_pend, dest.
REQ-019 Allocation: dispatch_rs_rdy at edge E writes the lowest-index non-busy entry; entry busy after E.
REQ-020 Dispatch with no free entry is dropped, state unchanged (not expected given REQ-021).
REQ-021 rs_full = combinational (number of non-busy entries <= 1), covering the one-cycle dispatch register delay.
REQ-022 Wakeup: at each edge, every busy entry with Qj_pend and Qj == an enabled CDB tag captures that value into Vj and clears Qj_pend; same for Qk.
REQ-023 Bypass at allocation: if an incoming pending tag matches an enabled CDB tag at the same edge, the value is captured and the entry written not pending.
REQ-024 Both CDBs matching the same tag at the same edge: ALU bus value wins.
REQ-025 Ready = busy and not Qj_pend and not Qk_pend, evaluated on registered state only.
REQ-026 Issue: at edge E, lowest-index ready entry (if any) copied to alu_* outputs, alu_en=1, entry cleared busy; at most one issue per edge.
REQ-027 No ready entry at edge E: alu_en=0 after E; payload outputs hold previous values.
REQ-028 Latency: dispatch with both operands ready at edge E -> alu_en high after edge E+1 at earliest; CDB wakeup at edge E -> issue at edge E+1 earliest.
REQ-029 Allocation and issue at the same edge are permitted; an entry freed at edge E is reusable from edge E+1.
REQ-030 rob_clear at edge E: all busy cleared, alu_en=0 after E, dispatch and CDB inputs at E ignored.
REQ-031 Priority: rst_in > rdy_in low > rob_clear > normal operation.

Reset
REQ-032 rst_in high at an edge: all busy=0, alu_en=0, all alu_* payload 0, regardless of rdy_in; rs_full=0 after reset.
REQ-033 Reset mid-operation discards all entries and any pending issue without producing alu_en.

Verification
REQ-034 Reset, dispatch ADDI inst=0x00500093 imme=5, rs1_val=7 not pending, dest=3 at edge 1 -> alu_en=1 after edge 2, alu_vj=7, alu_imme=5, alu_dest_tag=3; alu_en=0 after edge 3.
REQ-035 Dispatch rs1 pending tag 6; alu_cdb_en tag 6 val 0x1234 at edge 5 -> issue after edge 6 with alu_vj=0x1234; no issue before.
REQ-036 Dispatch pending tag 2 at the same edge as lsb_cdb_en tag 2 val 0xABCD -> entry ready, issues next edge with alu_vj=0xABCD.
REQ-037 Fill 7 entries all pending -> rs_full=1; broadcast waking entries 0 and 4 together -> entry 0 issues first, entry 4 next edge, rs_full=0 after the first issue.
REQ-038 Fill 4 entries then rob_clear -> no alu_en in any later cycle, rs_full=0; rdy_in low 3 cycles with a ready entry -> alu_en=0, issue resumes the edge rdy_in returns high.
